// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Two-requester burst arbiter and sequencer for the single-port data memory.
// Port 0 (core load/store) and port 1 (DMA/debug) each request a burst. The
// winner gets the memory for the whole burst. This block drives the per-beat
// word address and the write enable. Read data is returned combinationally.
//
// Optional feature macro: DMEM_ARB_RR_EN
//   defined   : round-robin on simultaneous requests. The port not granted
//               last wins.
//   undefined : fixed priority. Port 0 always wins a tie.
//
// Parameters
//   MEM_DEPTH  memory depth in words (power of two); AW = $clog2(MEM_DEPTH)
//   MAX_BURST  maximum beats per burst (power of two, <= 16)
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   pN_req              burst request, held until pN_gnt
//   pN_we               1 = write burst, 0 = read burst
//   pN_addr             base word index (bits [AW-1:0] used)
//   pN_len              beat count (0 -> 1, clamped to MAX_BURST)
//   pN_wdata            write data for the current beat
//   pN_gnt              pulse in the first beat cycle
//   pN_beat             high in every beat cycle of the granted burst
//   pN_done             high in the last beat cycle
//   pN_rdata            read data during read beats, else 0
//   mem_w_en/mem_addr/mem_w_data   memory-side controls
//   mem_r_data          combinational read data from memory

module dmem_arbiter #(
   parameter int MEM_DEPTH = 32,
   parameter int MAX_BURST = 8
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [4:0]  p0_len,
   input  logic [31:0] p0_wdata,
   output logic        p0_gnt,
   output logic        p0_beat,
   output logic        p0_done,
   output logic [31:0] p0_rdata,

   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [4:0]  p1_len,
   input  logic [31:0] p1_wdata,
   output logic        p1_gnt,
   output logic        p1_beat,
   output logic        p1_done,
   output logic [31:0] p1_rdata,

   output logic        mem_w_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_w_data,
   input  logic [31:0] mem_r_data
);

   localparam int AW = $clog2(MEM_DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [4:0]      cnt;
   logic [4:0]      cnt_nxt;
   logic            grant;
   logic            win;
   logic            last_beat;
   logic            busy;

   // Burst context captured at grant time.
   logic            owner;
   logic            we_r;
   logic [AW-1:0]   base;
   logic [4:0]      len_r;

   logic [AW-1:0]   addr_idx;
   logic            beat0;
   logic            beat1;

   // Only the low AW address bits select a word.
   logic            unused_addr_bits;
   assign unused_addr_bits = ^{p0_addr[31:AW], p1_addr[31:AW]};

   // Beat count saturation: a zero length still moves one word, and anything
   // larger than the longest burst is cut down to MAX_BURST.
   function automatic logic [4:0] clamp_len(input logic [4:0] len);
      if (len == 5'd0) begin
         return 5'd1;
      end
      if (len > 5'(MAX_BURST)) begin
         return 5'(MAX_BURST);
      end
      return len;
   endfunction

   // Winner selection. This result is only used when at least one request
   // is high.
`ifdef DMEM_ARB_RR_EN
   // last_gnt holds the port granted most recently. Its reset value of 1
   // makes port 0 the first winner of a tie.
   logic last_gnt;

   always_comb begin
      win = p1_req;
      if (p0_req && p1_req) begin
         win = ~last_gnt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_gnt <= 1'b1;
      end else if (grant) begin
         last_gnt <= win;
      end
   end
`else
   // Fixed priority: port 1 wins only when port 0 is not asking.
   assign win = p1_req & ~p0_req;
`endif

   assign busy      = (state == BUSY);
   assign last_beat = (cnt == (len_r - 5'd1));

   // Next-state and beat counter
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      grant     = 1'b0;
      case (state)
         IDLE: begin
            if (p0_req || p1_req) begin
               grant     = 1'b1;
               state_nxt = BUSY;
               cnt_nxt   = 5'd0;
            end
         end
         BUSY: begin
            // Leaving BUSY after every burst forces the single turnaround
            // cycle in which the next winner is picked.
            if (last_beat) begin
               state_nxt = IDLE;
               cnt_nxt   = 5'd0;
            end else begin
               cnt_nxt = cnt + 5'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 5'd0;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 5'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Burst context capture. No reset is needed here: these registers are
   // only observed while BUSY, and BUSY is always entered through a grant.
   always_ff @(posedge clk) begin
      if (grant) begin
         owner <= win;
         we_r  <= win ? p1_we : p0_we;
         base  <= win ? p1_addr[AW-1:0] : p0_addr[AW-1:0];
         len_r <= clamp_len(win ? p1_len : p0_len);
      end
   end

   // Beat outputs
   // The AW-bit add wraps the burst within the memory.
   assign addr_idx = base + AW'(cnt);

   assign beat0 = busy & ~owner;
   assign beat1 = busy &  owner;

   assign p0_beat = beat0;
   assign p1_beat = beat1;
   assign p0_gnt  = beat0 & (cnt == 5'd0);
   assign p1_gnt  = beat1 & (cnt == 5'd0);
   assign p0_done = beat0 & last_beat;
   assign p1_done = beat1 & last_beat;

   assign mem_w_en   = busy & we_r;
   assign mem_addr   = busy ? {{(32-AW){1'b0}}, addr_idx} : 32'd0;
   assign mem_w_data = (busy & we_r) ? (owner ? p1_wdata : p0_wdata) : 32'd0;

   assign p0_rdata = (beat0 & ~we_r) ? mem_r_data : 32'd0;
   assign p1_rdata = (beat1 & ~we_r) ? mem_r_data : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//
// Cycle-by-cycle vector bench for dmem_arbiter with a 32-word behavioural
// memory. Each table row holds the inputs for one clock cycle and the outputs
// expected in that same cycle. After the table runs, the memory contents are
// checked for the reset-abort case.

module tb_dmem_arbiter;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;
`ifdef DMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [4:0]  p0_len, p1_len;
   logic        p0_gnt, p0_beat, p0_done, p1_gnt, p1_beat, p1_done;
   logic [31:0] p0_rdata, p1_rdata;
   logic        mem_w_en;
   logic [31:0] mem_addr, mem_w_data, mem_r_data;

   logic        mem_init;
   logic [31:0] mem [32];

   int n_cmp;
   int n_bad;

   dmem_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .p0_req     (p0_req),
      .p0_we      (p0_we),
      .p0_addr    (p0_addr),
      .p0_len     (p0_len),
      .p0_wdata   (p0_wdata),
      .p0_gnt     (p0_gnt),
      .p0_beat    (p0_beat),
      .p0_done    (p0_done),
      .p0_rdata   (p0_rdata),
      .p1_req     (p1_req),
      .p1_we      (p1_we),
      .p1_addr    (p1_addr),
      .p1_len     (p1_len),
      .p1_wdata   (p1_wdata),
      .p1_gnt     (p1_gnt),
      .p1_beat    (p1_beat),
      .p1_done    (p1_done),
      .p1_rdata   (p1_rdata),
      .mem_w_en   (mem_w_en),
      .mem_addr   (mem_addr),
      .mem_w_data (mem_w_data),
      .mem_r_data (mem_r_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural memory: write commits at the edge, read is combinational.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'h1000 + 32'(i);
      end else if (mem_w_en) begin
         mem[mem_addr[4:0]] <= mem_w_data;
      end
   end
   assign mem_r_data = mem[mem_addr[4:0]];

   // ctl = {p0_gnt, p0_beat, p0_done, p1_gnt, p1_beat, p1_done, mem_w_en}
   typedef struct {
      string       name;
      logic        rs;
      logic        r0, w0;
      logic [31:0] a0;
      logic [4:0]  l0;
      logic [31:0] d0;
      logic        r1, w1;
      logic [31:0] a1;
      logic [4:0]  l1;
      logic [31:0] d1;
      logic [6:0]  ctl;
      logic [31:0] addr, wd, q0, q1;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input string n, input logic rs,
                              input logic r0, input logic w0, input logic [31:0] a0,
                              input logic [4:0] l0, input logic [31:0] d0,
                              input logic r1, input logic w1, input logic [31:0] a1,
                              input logic [4:0] l1, input logic [31:0] d1,
                              input logic [6:0] c, input logic [31:0] ad,
                              input logic [31:0] wd, input logic [31:0] q0,
                              input logic [31:0] q1);
      vec_t t;
      t.name = n; t.rs = rs;
      t.r0 = r0; t.w0 = w0; t.a0 = a0; t.l0 = l0; t.d0 = d0;
      t.r1 = r1; t.w1 = w1; t.a1 = a1; t.l1 = l1; t.d1 = d1;
      t.ctl = c; t.addr = ad; t.wd = wd; t.q0 = q0; t.q1 = q1;
      return t;
   endfunction

   function automatic vec_t idle(input string n);
      return v(n, H, L, L, 0, 5'd0, 0, L, L, 0, 5'd0, 0, 7'b0, 0, 0, 0, 0);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0]  act_ctl;
      logic [31:0] exp_mem [8];

      n_cmp = 0;
      n_bad = 0;

      // Single write then read on port 0
      tbl.push_back(idle("reset_state"));
      tbl.push_back(v("w_req", H, H, H, 3, 5'd4, 32'hA0, L, L, 0, 5'd0, 0, 7'b0000000, 0, 0, 0, 0));
      tbl.push_back(v("w_b0",  H, L, H, 3, 5'd4, 32'hA0, L, L, 0, 5'd0, 0, 7'b1100001, 3, 32'hA0, 0, 0));
      tbl.push_back(v("w_b1",  H, L, H, 3, 5'd4, 32'hA1, L, L, 0, 5'd0, 0, 7'b0100001, 4, 32'hA1, 0, 0));
      tbl.push_back(v("w_b2",  H, L, H, 3, 5'd4, 32'hA2, L, L, 0, 5'd0, 0, 7'b0100001, 5, 32'hA2, 0, 0));
      tbl.push_back(v("w_b3",  H, L, H, 3, 5'd4, 32'hA3, L, L, 0, 5'd0, 0, 7'b0110001, 6, 32'hA3, 0, 0));
      tbl.push_back(v("r_req", H, H, L, 3, 5'd4, 0, L, L, 0, 5'd0, 0, 7'b0000000, 0, 0, 0, 0));
      tbl.push_back(v("r_b0",  H, L, L, 3, 5'd4, 0, L, L, 0, 5'd0, 0, 7'b1100000, 3, 0, 32'hA0, 0));
      tbl.push_back(v("r_b1",  H, L, L, 3, 5'd4, 0, L, L, 0, 5'd0, 0, 7'b0100000, 4, 0, 32'hA1, 0));
      tbl.push_back(v("r_b2",  H, L, L, 3, 5'd4, 0, L, L, 0, 5'd0, 0, 7'b0100000, 5, 0, 32'hA2, 0));
      tbl.push_back(v("r_b3",  H, L, L, 3, 5'd4, 0, L, L, 0, 5'd0, 0, 7'b0110000, 6, 0, 32'hA3, 0));
      // Wrap-around write on port 1
      tbl.push_back(v("wrap_req", H, L, L, 0, 5'd0, 0, H, H, 30, 5'd4, 32'hB0, 7'b0000000, 0, 0, 0, 0));
      tbl.push_back(v("wrap_b0",  H, L, L, 0, 5'd0, 0, L, H, 30, 5'd4, 32'hB0, 7'b0001101, 30, 32'hB0, 0, 0));
      tbl.push_back(v("wrap_b1",  H, L, L, 0, 5'd0, 0, L, H, 30, 5'd4, 32'hB1, 7'b0000101, 31, 32'hB1, 0, 0));
      tbl.push_back(v("wrap_b2",  H, L, L, 0, 5'd0, 0, L, H, 30, 5'd4, 32'hB2, 7'b0000101, 0, 32'hB2, 0, 0));
      tbl.push_back(v("wrap_b3",  H, L, L, 0, 5'd0, 0, L, H, 30, 5'd4, 32'hB3, 7'b0000111, 1, 32'hB3, 0, 0));
      // Length 0 read of addr 0 returns the third beat of the wrap burst
      tbl.push_back(v("len0_req", H, H, L, 0, 5'd0, 0, L, L, 0, 5'd0, 0, 7'b0000000, 0, 0, 0, 0));
      tbl.push_back(v("len0_b0",  H, L, L, 0, 5'd0, 0, L, L, 0, 5'd0, 0, 7'b1110000, 0, 0, 32'hB2, 0));
      // Length 20 clamps to 8 beats
      tbl.push_back(v("len20_req", H, L, L, 0, 5'd0, 0, H, H, 8, 5'd20, 32'hC0, 7'b0000000, 0, 0, 0, 0));
      for (int i = 0; i < 8; i++) begin
         tbl.push_back(v($sformatf("len20_b%0d", i), H, L, L, 0, 5'd0, 0, L, H, 8, 5'd20,
                         32'hC0 + 32'(i),
                         (i == 0) ? 7'b0001101 : ((i == 7) ? 7'b0000111 : 7'b0000101),
                         32'd8 + 32'(i), 32'hC0 + 32'(i), 0, 0));
      end
      // Ties: both ports hold a len-2 read request every cycle
      for (int k = 0; k < 2; k++) begin
         tbl.push_back(v($sformatf("tie%0d_idle_a", k), H, H, L, 8, 5'd2, 0, H, L, 12, 5'd2, 0, 7'b0000000, 0, 0, 0, 0));
         tbl.push_back(v($sformatf("tie%0d_a0", k), H, H, L, 8, 5'd2, 0, H, L, 12, 5'd2, 0, 7'b1100000, 8, 0, 32'hC0, 0));
         tbl.push_back(v($sformatf("tie%0d_a1", k), H, H, L, 8, 5'd2, 0, H, L, 12, 5'd2, 0, 7'b0110000, 9, 0, 32'hC1, 0));
         tbl.push_back(v($sformatf("tie%0d_idle_b", k), H, H, L, 8, 5'd2, 0, H, L, 12, 5'd2, 0, 7'b0000000, 0, 0, 0, 0));
         if (RR) begin
            tbl.push_back(v($sformatf("tie%0d_b0", k), H, H, L, 8, 5'd2, 0, H, L, 12, 5'd2, 0, 7'b0001100, 12, 0, 0, 32'hC4));
            tbl.push_back(v($sformatf("tie%0d_b1", k), H, H, L, 8, 5'd2, 0, H, L, 12, 5'd2, 0, 7'b0000110, 13, 0, 0, 32'hC5));
         end else begin
            tbl.push_back(v($sformatf("tie%0d_b0", k), H, H, L, 8, 5'd2, 0, H, L, 12, 5'd2, 0, 7'b1100000, 8, 0, 32'hC0, 0));
            tbl.push_back(v($sformatf("tie%0d_b1", k), H, H, L, 8, 5'd2, 0, H, L, 12, 5'd2, 0, 7'b0110000, 9, 0, 32'hC1, 0));
         end
      end
      tbl.push_back(idle("tie_off"));
      // Reset during the third beat of a len-8 write
      tbl.push_back(v("rst_req", H, H, H, 0, 5'd8, 32'hD0, L, L, 0, 5'd0, 0, 7'b0000000, 0, 0, 0, 0));
      tbl.push_back(v("rst_b0",  H, L, H, 0, 5'd8, 32'hD0, L, L, 0, 5'd0, 0, 7'b1100001, 0, 32'hD0, 0, 0));
      tbl.push_back(v("rst_b1",  H, L, H, 0, 5'd8, 32'hD1, L, L, 0, 5'd0, 0, 7'b0100001, 1, 32'hD1, 0, 0));
      tbl.push_back(v("rst_b2",  L, L, H, 0, 5'd8, 32'hD2, L, L, 0, 5'd0, 0, 7'b0100001, 2, 32'hD2, 0, 0));
      tbl.push_back(v("rst_after", H, L, H, 0, 5'd8, 32'hD3, L, L, 0, 5'd0, 0, 7'b0000000, 0, 0, 0, 0));
      tbl.push_back(idle("rst_after2"));
      // After reset the round-robin pointer favours port 0 again
      tbl.push_back(v("rr_req", H, H, L, 0, 5'd1, 0, H, L, 0, 5'd1, 0, 7'b0000000, 0, 0, 0, 0));
      tbl.push_back(v("rr_b0",  H, L, L, 0, 5'd1, 0, L, L, 0, 5'd1, 0, 7'b1110000, 0, 0, 32'hD0, 0));
      tbl.push_back(idle("rr_end"));

      // Initial reset and memory fill
      rst_n = 1'b0; mem_init = 1'b1;
      p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_len = '0; p0_wdata = '0;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_len = '0; p1_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      mem_init = 1'b0;
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         rst_n    = tbl[i].rs;
         p0_req   = tbl[i].r0; p0_we = tbl[i].w0; p0_addr = tbl[i].a0;
         p0_len   = tbl[i].l0; p0_wdata = tbl[i].d0;
         p1_req   = tbl[i].r1; p1_we = tbl[i].w1; p1_addr = tbl[i].a1;
         p1_len   = tbl[i].l1; p1_wdata = tbl[i].d1;
         @(negedge clk);
         act_ctl = {p0_gnt, p0_beat, p0_done, p1_gnt, p1_beat, p1_done, mem_w_en};
         n_cmp++;
         if ({act_ctl, mem_addr, mem_w_data, p0_rdata, p1_rdata} !==
             {tbl[i].ctl, tbl[i].addr, tbl[i].wd, tbl[i].q0, tbl[i].q1}) begin
            n_bad++;
            $display("FAIL %s: got ctl=%b addr=%0d wdata=%h rd0=%h rd1=%h, want ctl=%b addr=%0d wdata=%h rd0=%h rd1=%h",
                     tbl[i].name, act_ctl, mem_addr, mem_w_data, p0_rdata, p1_rdata,
                     tbl[i].ctl, tbl[i].addr, tbl[i].wd, tbl[i].q0, tbl[i].q1);
         end
         @(posedge clk);
         #1;
      end

      // Memory after the aborted burst: words 0-2 rewritten, 3-7 untouched.
      exp_mem[0] = 32'hD0; exp_mem[1] = 32'hD1; exp_mem[2] = 32'hD2;
      exp_mem[3] = 32'hA0; exp_mem[4] = 32'hA1; exp_mem[5] = 32'hA2;
      exp_mem[6] = 32'hA3; exp_mem[7] = 32'h1007;
      @(negedge clk);
      for (int a = 0; a < 8; a++) begin
         n_cmp++;
         if (mem[a] !== exp_mem[a]) begin
            n_bad++;
            $display("FAIL mem_word_%0d: got %h, want %h", a, mem[a], exp_mem[a]);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester burst arbiter and sequencer in front of the single-port 32-word data memory. It grants the memory to either the core load/store port (port 0) or the DMA/debug port (port 1) one burst at a time. It generates the per-beat word address and write enable, and returns read data with a per-beat strobe. It sits between the requesters and the memory's `w_en`/`addr`/`w_data`/`r_data` pins.

## Interface
- `MEM_DEPTH`, 32, memory depth in words; power of two; `AW = $clog2(MEM_DEPTH)`.
- `MAX_BURST`, 8, maximum beats per burst; power of two ≤ 16.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `pN_req`  in  1  request (N = 0, 1); held high until `pN_gnt`.
- `pN_we`  in  1  1 = write burst, 0 = read burst; stable while `pN_req` is high.
- `pN_addr`  in  32  base word index; only bits [AW-1:0] are used.
- `pN_len`  in  5  beat count; 0 is treated as 1; values above MAX_BURST are clamped to MAX_BURST.
- `pN_wdata`  in  32  write data for the current beat.
- `pN_gnt`  out  1  one-cycle pulse in the first beat cycle of the granted burst.
- `pN_beat`  out  1  high in every beat cycle of the granted burst.
- `pN_done`  out  1  high in the last beat cycle.
- `pN_rdata`  out  32  read data; valid when `pN_beat` is high and `pN_we` is 0; otherwise 0.
- `mem_w_en`  out  1  to memory `w_en`.
- `mem_addr`  out  32  to memory `addr`; zero-extended AW-bit index.
- `mem_w_data`  out  32  to memory `w_data`.
- `mem_r_data`  in  32  from memory `r_data`; combinational read.

## Operation
- States:
  - IDLE: arbitrate.
  - BUSY: issue beats.
- IDLE with any `pN_req` high at an edge: latch the winner, its `we`, `addr[AW-1:0]` as base, and its clamped length. Go to BUSY and set beat counter i = 0.
- IDLE with no request: remain in IDLE.
- Arbitration with a single requester: that port wins.
- Arbitration with simultaneous requests: see Configuration.
- BUSY, each cycle:
  - `mem_addr = (base + i) mod MEM_DEPTH`; address wraps within the memory, upper bits are 0.
  - Write burst: `mem_w_en = 1` and `mem_w_data` = winner's `pN_wdata`, combinational pass-through.
  - Read burst: `mem_w_en = 0` and `pN_rdata` = `mem_r_data`, combinational.
  - i increments at each edge.
  - On the edge ending beat i = len-1, return to IDLE.
- The loser's `gnt`/`beat`/`done`/`rdata` stay 0. Its request stays pending.
- The `pN_req` level during BUSY is ignored. A request deasserted mid-burst does not shorten the burst.
- Outside BUSY: `mem_w_en`, `mem_addr`, `mem_w_data` are 0.

## Timing
- Request sampled at edge T. `gnt`, the first `beat`, and the first memory access occur in cycle T+1. The last beat is in cycle T+len.
- Memory write for beat i commits at the edge ending that beat cycle.
- Read data for a beat is valid in the same cycle (zero-latency pass-through).
- `done` coincides with `gnt` when len = 1.
- One mandatory IDLE cycle between bursts is the arbitration turnaround. Back-to-back requesters therefore see bursts separated by exactly one idle cycle.
- Reset: when `rst_n` = 0 at an edge:
  - State goes to IDLE. All outputs are 0 the following cycle.
  - The round-robin pointer selects port 0 next.
  - An in-flight burst is abandoned; beats already written remain in memory and no further writes occur.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. A 1-bit last-grant register resets to 1. On a tie, the port not granted last wins. The register updates on every grant.
- `DMEM_ARB_RR_EN` undefined: fixed priority, port 0 always wins ties. Port 1 can starve.

## Test plan
- Single write then read:
  - p0 writes len 4 at addr 3 with data 0xA0..0xA3 → `mem_w_en` high for 4 cycles at addrs 3,4,5,6; `p0_done` in the 4th beat.
  - p0 then reads len 4 at addr 3 → `p0_rdata` = 0xA0,0xA1,0xA2,0xA3.
- Wrap: p1 writes len 4 at addr 30 → `mem_addr` = 30,31,0,1. A readback at addr 0 returns beat 3's data.
- Length edges:
  - len 0 → 1 beat with `gnt` and `done` in the same cycle.
  - len 20 → 8 beats.
- Tie:
  - Both ports request every cycle with len 2.
  - RR_EN: grants go p0,p1,p0,p1, each burst separated by 1 idle cycle.
  - Without RR_EN: p0 only.
- Reset mid-burst: p0 writes len 8 at addr 0 and `rst_n` drops during beat 3 → addrs 0–2 written, addrs 3–7 unchanged, all outputs 0 the cycle after the reset edge.
